// File: rtl/tm1683_display_loader.sv
// Latches decoder digit words on sync and streams one TM1683 refresh frame:
// data-mode command, address command, N segment bytes, display-control command.
module tm1683_display_loader #(
  parameter int unsigned N_DIGITS  = 8,
  parameter logic [3:0]  BASE_ADDR = 4'h0
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        sync_in,
  input  logic [39:0] dec_in,
  input  logic [7:0]  point_in,
  input  logic [2:0]  brightness,
  input  logic        disp_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD_DATA = 3'd1;
  localparam logic [2:0] S_CMD_ADDR = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_CMD_CTRL = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [2:0] CNT_INIT = 3'(N_DIGITS - 1);

  typedef struct packed {
    logic [39:0] dec;
    logic [7:0]  point;
    logic [2:0]  bright;
    logic        en;
  } frame_t;

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  frame_t     work_q, work_d, shadow_q, shadow_d, sample;
  logic       accept;
  logic [4:0] digit_code;
  logic       digit_dp;

  assign sample = {dec_in, point_in, brightness, disp_en};
  assign accept = tx_valid & tx_ready;

  function automatic logic [6:0] seg7(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'h00: s = 7'h3F;  5'h01: s = 7'h06;  5'h02: s = 7'h5B;  5'h03: s = 7'h4F;
      5'h04: s = 7'h66;  5'h05: s = 7'h6D;  5'h06: s = 7'h7D;  5'h07: s = 7'h07;
      5'h08: s = 7'h7F;  5'h09: s = 7'h6F;  5'h0A: s = 7'h77;  5'h0B: s = 7'h7C;
      5'h0C: s = 7'h39;  5'h0D: s = 7'h5E;  5'h0E: s = 7'h79;  5'h0F: s = 7'h71;
      5'h10: s = 7'h79;  5'h11: s = 7'h40;  5'h12: s = 7'h3F;  5'h13: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Digit select: the counter walks from the leftmost sent digit down to digit 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    digit_code = 5'h1F;
    digit_dp   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cnt_q == 3'(i)) begin
        digit_code = work_q.dec[5*i +: 5];
        digit_dp   = work_q.point[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    work_d    = work_q;
    shadow_d  = shadow_q;

    // A sync mid-frame parks in the shadow; the newest one wins.
    if (sync_in && state_q != S_IDLE && state_q != S_DONE) begin
      shadow_d  = sample;
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (sync_in) begin
        work_d  = sample;
        state_d = S_CMD_DATA;
      end
      S_CMD_DATA: if (accept) state_d = S_CMD_ADDR;
      S_CMD_ADDR: if (accept) begin
        state_d = S_DATA;
        cnt_d   = CNT_INIT;
      end
      S_DATA: if (accept) begin
        if (cnt_q == 3'd0) state_d = S_CMD_CTRL;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_CMD_CTRL: if (accept) state_d = S_DONE;
      S_DONE: begin
        if (sync_in) begin
          work_d    = sample;
          pending_d = 1'b0;
          state_d   = S_CMD_DATA;
        end else if (pending_q) begin
          work_d    = shadow_q;
          pending_d = 1'b0;
          state_d   = S_CMD_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    case (state_q)
      S_CMD_DATA: begin
        tx_valid = 1'b1;
        tx_data  = 8'h40;
        tx_last  = 1'b1;
      end
      S_CMD_ADDR: begin
        tx_valid = 1'b1;
        tx_data  = {4'hC, BASE_ADDR};
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = {digit_dp, seg7(digit_code)};
        tx_last  = (cnt_q == 3'd0);
      end
      S_CMD_CTRL: begin
        tx_valid = 1'b1;
        tx_data  = work_q.en ? {5'b10001, work_q.bright} : 8'h80;
        tx_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the digit registers are ordinary flops, so clearing them costs nothing and keeps post-reset state fully defined.
      state_q   <= S_IDLE;
      cnt_q     <= CNT_INIT;
      pending_q <= 1'b0;
      work_q    <= '0;
      shadow_q  <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      work_q    <= work_d;
      shadow_q  <= shadow_d;
    end
  end

endmodule

// File: tb/tb_tm1683_display_loader.sv
// Table vectors plus randomized frames checked against a frame-level model;
// a second instance (3 digits, base address 3) exercises the parameters.
`timescale 1ns/1ps
module tb_tm1683_display_loader;

  typedef struct packed {
    logic [39:0] dec;
    logic [7:0]  point;
    logic [2:0]  bright;
    logic        en;
  } frame_t;

  typedef struct {
    int         cyc;
    logic [8:0] b;
  } xfer_t;

  typedef struct {
    frame_t     f;
    logic [8:0] exp [11];
  } vec_t;

  localparam int         NB     = 3;
  localparam logic [3:0] BASE_B = 4'h3;

  logic        mclk = 1'b0, rst_n = 1'b0, sync_in = 1'b0, tx_ready = 1'b1, disp_en = 1'b0;
  logic [39:0] dec_in = '0;
  logic [7:0]  point_in = '0;
  logic [2:0]  brightness = '0;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_valid_a, tx_valid_b, tx_last_a, tx_last_b;
  logic        busy_a, busy_b, done_a, done_b;

  int cyc = 0, tests = 0, fails = 0, sync_cyc = 0;
  int exp_done_a = 0, exp_done_b = 0;
  xfer_t      got_a[$], got_b[$];
  int         done_a_q[$], done_b_q[$];
  logic [8:0] exp_a[$], exp_b[$];
  logic [6:0] glyph [32];
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic [9:0] held_a, held_b;
  vec_t       vt [5];

  tm1683_display_loader dut_a (
    .mclk(mclk), .rst_n(rst_n), .sync_in(sync_in), .dec_in(dec_in), .point_in(point_in),
    .brightness(brightness), .disp_en(disp_en), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_last(tx_last_a), .tx_ready(tx_ready), .busy(busy_a), .done(done_a)
  );

  tm1683_display_loader #(.N_DIGITS(NB), .BASE_ADDR(BASE_B)) dut_b (
    .mclk(mclk), .rst_n(rst_n), .sync_in(sync_in), .dec_in(dec_in), .point_in(point_in),
    .brightness(brightness), .disp_en(disp_en), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_last(tx_last_b), .tx_ready(tx_ready), .busy(busy_b), .done(done_b)
  );

  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Transfer monitors: sampled on the falling edge, away from the active edge.
  always @(negedge mclk) begin
    if (!rst_n) stall_a = 1'b0;
    else begin
      if (stall_a) check("hold_a", {tx_valid_a, tx_last_a, tx_data_a}, held_a);
      if (tx_valid_a && tx_ready) got_a.push_back('{cyc, {tx_last_a, tx_data_a}});
      stall_a = tx_valid_a && !tx_ready;
      held_a  = {tx_valid_a, tx_last_a, tx_data_a};
      if (done_a) done_a_q.push_back(cyc);
    end
  end

  always @(negedge mclk) begin
    if (!rst_n) stall_b = 1'b0;
    else begin
      if (stall_b) check("hold_b", {tx_valid_b, tx_last_b, tx_data_b}, held_b);
      if (tx_valid_b && tx_ready) got_b.push_back('{cyc, {tx_last_b, tx_data_b}});
      stall_b = tx_valid_b && !tx_ready;
      held_b  = {tx_valid_b, tx_last_b, tx_data_b};
      if (done_b) done_b_q.push_back(cyc);
    end
  end

  // Frame-level reference: byte k of a frame for an n-digit display at address base.
  function automatic logic [8:0] model_byte(input frame_t f, input int n, input logic [3:0] base,
                                            input int k);
    int         d;
    logic [4:0] code;
    if (k == 0) return 9'h140;
    if (k == 1) return {1'b0, 4'hC, base};
    if (k < n + 2) begin
      d    = n - 1 - (k - 2);
      code = f.dec[5*d +: 5];
      return {(k == n + 1), f.point[d], glyph[code]};
    end
    return {1'b1, f.en ? {5'b10001, f.bright} : 8'h80};
  endfunction

  task automatic model_push(input frame_t f, input bit push_a);
    if (push_a) begin
      for (int k = 0; k < 11; k++) exp_a.push_back(model_byte(f, 8, 4'h0, k));
      exp_done_a++;
    end
    for (int k = 0; k < NB + 3; k++) exp_b.push_back(model_byte(f, NB, BASE_B, k));
    exp_done_b++;
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic drive_sync(input frame_t f);
    {dec_in, point_in, brightness, disp_en} = f;
    sync_in  = 1'b1;
    sync_cyc = cyc;
    step();
    sync_in = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while ((busy_a || busy_b) && n < 3000) begin
      if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    tx_ready = 1'b1;
    check("idle_timeout", (n < 3000), 1);
  endtask

  task automatic clear_all();
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    done_a_q.delete(); done_b_q.delete();
    exp_done_a = 0; exp_done_b = 0;
  endtask

  task automatic check_streams(input string name);
    check({name, " len_a"}, got_a.size(), exp_a.size());
    for (int k = 0; k < exp_a.size() && k < got_a.size(); k++)
      check($sformatf("%s a[%0d]", name, k), got_a[k].b, exp_a[k]);
    check({name, " len_b"}, got_b.size(), exp_b.size());
    for (int k = 0; k < exp_b.size() && k < got_b.size(); k++)
      check($sformatf("%s b[%0d]", name, k), got_b[k].b, exp_b[k]);
    check({name, " done_a"}, done_a_q.size(), exp_done_a);
    check({name, " done_b"}, done_b_q.size(), exp_done_b);
    clear_all();
  endtask

  // Full-rate frame on dut_a: 11 back-to-back transfers, done right after the last.
  task automatic check_timing_a(input string name);
    for (int k = 0; k < got_a.size() && k < 11; k++)
      check($sformatf("%s cyc[%0d]", name, k), got_a[k].cyc, sync_cyc + 1 + k);
    if (done_a_q.size() > 0) check({name, " done_cyc"}, done_a_q[0], sync_cyc + 12);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    int     r;
    f.dec    = {$urandom, $urandom_range(0, 255)};
    r        = $urandom_range(0, 8);
    f.point  = (r == 8) ? 8'h00 : 8'(1 << r);
    f.bright = 3'($urandom_range(0, 7));
    f.en     = 1'($urandom_range(0, 1));
    return f;
  endfunction

  initial begin
    frame_t fa, fb, fc;
    int     c1;

    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71,
              7'h79, 7'h40, 7'h3F, 7'h71, 7'h00, 7'h00, 7'h00, 7'h00,
              7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    vt[0].f   = {{5'h1F, 5'h1F, 5'h1F, 5'h11, 5'h01, 5'h02, 5'h03, 5'h04}, 8'h04, 3'd7, 1'b1};
    vt[0].exp = '{9'h140, 9'h0C0, 9'h000, 9'h000, 9'h000, 9'h040, 9'h006, 9'h0DB, 9'h04F, 9'h166, 9'h18F};
    vt[1].f   = {{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h11, 5'h12, 5'h13}, 8'h03, 3'd2, 1'b1};
    vt[1].exp = '{9'h140, 9'h0C0, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h040, 9'h0BF, 9'h1F1, 9'h18A};
    vt[2].f   = {{5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F, 5'h10, 5'h09}, 8'h80, 3'd5, 1'b0};
    vt[2].exp = '{9'h140, 9'h0C0, 9'h0F7, 9'h07C, 9'h039, 9'h05E, 9'h079, 9'h071, 9'h079, 9'h16F, 9'h180};
    vt[3].f   = {{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07}, 8'h00, 3'd0, 1'b1};
    vt[3].exp = '{9'h140, 9'h0C0, 9'h03F, 9'h006, 9'h05B, 9'h04F, 9'h066, 9'h06D, 9'h07D, 9'h107, 9'h188};
    vt[4].f   = {{5'h08, 5'h09, 5'h14, 5'h1E, 5'h12, 5'h13, 5'h00, 5'h11}, 8'h01, 3'd3, 1'b1};
    vt[4].exp = '{9'h140, 9'h0C0, 9'h07F, 9'h06F, 9'h000, 9'h000, 9'h03F, 9'h071, 9'h03F, 9'h1C0, 9'h18B};

    // Reset state
    #1;
    check("rst_a", {tx_data_a, tx_valid_a, tx_last_a, busy_a, done_a}, 12'h000);
    check("rst_b", {tx_data_b, tx_valid_b, tx_last_b, busy_b, done_b}, 12'h000);
    repeat (3) @(posedge mclk);
    #3 rst_n = 1'b1;
    step();

    // Table vectors at full rate
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 11; k++) exp_a.push_back(vt[t].exp[k]);
      exp_done_a++;
      model_push(vt[t].f, 1'b0);
      drive_sync(vt[t].f);
      wait_idle(1'b0);
      check_timing_a($sformatf("vec%0d", t));
      if (got_b.size() > 1) check("addr_b", got_b[1].b, 9'h0C3);
      check_streams($sformatf("vec%0d", t));
    end

    // Backpressure: ready low for 5 cycles while digit byte 06 is presented
    model_push(vt[0].f, 1'b1);
    drive_sync(vt[0].f);
    c1 = sync_cyc;
    goto_cyc(c1 + 7);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge mclk);
      check($sformatf("bp_hold%0d", i), {tx_valid_a, tx_data_a}, 9'h106);
      step();
    end
    tx_ready = 1'b1;
    wait_idle(1'b0);
    check_streams("backpressure");

    // Two syncs mid-frame: current frame finishes, then exactly one frame with the latest
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    model_push(fa, 1'b1);
    model_push(fc, 1'b1);
    drive_sync(fa);
    c1 = sync_cyc;
    goto_cyc(c1 + 3);
    drive_sync(fb);
    goto_cyc(c1 + 5);
    drive_sync(fc);
    wait_idle(1'b0);
    check_streams("two_syncs");

    // Sync landing exactly in DONE starts the next frame without passing through IDLE
    fa = rand_frame(); fb = rand_frame();
    model_push(fa, 1'b1);
    model_push(fb, 1'b1);
    drive_sync(fa);
    c1 = sync_cyc;
    goto_cyc(c1 + 12);
    drive_sync(fb);
    wait_idle(1'b0);
    if (done_a_q.size() > 0) check("done_sync_done", done_a_q[0], c1 + 12);
    if (got_a.size() > 11) check("done_sync_next", got_a[11].cyc, c1 + 13);
    check_streams("sync_in_done");

    // Asynchronous reset in the middle of the digit bytes
    drive_sync(vt[0].f);
    c1 = sync_cyc;
    goto_cyc(c1 + 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", {tx_valid_a, busy_a, tx_last_a, tx_data_a}, 11'h000);
    check("arst_b", {tx_valid_b, busy_b, tx_last_b, tx_data_b}, 11'h000);
    clear_all();
    repeat (2) @(posedge mclk);
    #3 rst_n = 1'b1;
    repeat (4) step();
    check("arst_quiet", got_a.size() + got_b.size(), 0);
    check("arst_idle", {busy_a, busy_b}, 2'b00);
    for (int k = 0; k < 11; k++) exp_a.push_back(vt[3].exp[k]);
    exp_done_a++;
    model_push(vt[3].f, 1'b0);
    drive_sync(vt[3].f);
    wait_idle(1'b0);
    check_timing_a("post_rst");
    check_streams("post_rst");

    // Random frames under random backpressure
    for (int r = 0; r < 40; r++) begin
      fa = rand_frame();
      model_push(fa, 1'b1);
      drive_sync(fa);
      wait_idle(1'b1);
      check_streams($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
